// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: writable instruction memory for the RISC-V core.
// A boot loader streams program bytes (little-endian within each word) into
// the array, and once the load completes, fetch reads words through a
// registered request/response port.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   load_start_i          pulse: begin a new load (clears pointer, error, partial word)
//   load_byte_valid_i     load_byte_i carries a program byte this cycle
//   load_byte_i           program byte
//   load_done_i           pulse: end of program stream, flush any partial word
//   load_err_o            sticky: a byte arrived after the array was full
//   loaded_words_o        words written by the last or current load
//   run_o                 fetch is enabled
//   fetch_req_i           fetch request
//   fetch_addr_i          byte address of the requested instruction
//   fetch_gnt_o           request accepted this cycle (combinational)
//   rsp_valid_o           response valid
//   rsp_ready_i           consumer accepts the response
//   rsp_data_o            instruction word, or FAULT_WORD on a fault
//   rsp_fault_o           request was misaligned or out of range
module instr_mem_loadable #(
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        DEPTH      = 256,
    parameter int unsigned        ADDR_W     = 10,
    parameter logic [DATA_W-1:0]  FAULT_WORD = DATA_W'(32'h0000_0013)
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        load_start_i,
    input  logic                        load_byte_valid_i,
    input  logic [7:0]                  load_byte_i,
    input  logic                        load_done_i,
    output logic                        load_err_o,
    output logic [$clog2(DEPTH+1)-1:0]  loaded_words_o,
    output logic                        run_o,
    input  logic                        fetch_req_i,
    input  logic [ADDR_W-1:0]           fetch_addr_i,
    output logic                        fetch_gnt_o,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [DATA_W-1:0]           rsp_data_o,
    output logic                        rsp_fault_o
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned OFS    = $clog2(BYTES);
    localparam int unsigned BC_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    ptr_q,  ptr_d;
    logic [BC_W-1:0]     bc_q,   bc_d;
    logic [DATA_W-1:0]   buf_q,  buf_d;
    logic                err_q,  err_d;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_fault_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [MEM_AW-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   byte_merged;

    logic [ADDR_W-1:0]   word_idx;
    logic                misalign;
    logic                out_of_range;
    logic                fault_c;

    // Load datapath: merge the incoming byte, commit full words, flush on done.
    always_comb begin
        ptr_d       = ptr_q;
        bc_d        = bc_q;
        buf_d       = buf_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_waddr   = MEM_AW'(ptr_q);
        mem_wdata   = buf_q;
        byte_merged = buf_q;
        if (load_start_i) begin
            ptr_d = '0;
            bc_d  = '0;
            buf_d = '0;
            err_d = 1'b0;
        end else if (state_q == ST_LOAD) begin
            if (load_byte_valid_i) begin
                if (ptr_q == CNT_W'(DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    byte_merged[{bc_q, 3'b000} +: 8] = load_byte_i;
                    if (bc_q == BC_W'(BYTES - 1)) begin
                        mem_we    = 1'b1;
                        mem_wdata = byte_merged;
                        ptr_d     = ptr_q + 1'b1;
                        bc_d      = '0;
                        buf_d     = '0;
                    end else begin
                        bc_d  = bc_q + 1'b1;
                        buf_d = byte_merged;
                    end
                end
            end
            // A partial word only exists while the pointer is below DEPTH, and a
            // word completed this cycle leaves bc_d at zero, so at most one write.
            // Unused lanes are already zero because the buffer clears per word.
            if (load_done_i && (bc_d != '0)) begin
                mem_we    = 1'b1;
                mem_wdata = buf_d;
                ptr_d     = ptr_d + 1'b1;
                bc_d      = '0;
                buf_d     = '0;
            end
        end
    end

    // Fetch decode.
    always_comb begin
        word_idx     = fetch_addr_i >> OFS;
        misalign     = (fetch_addr_i & ADDR_W'(BYTES - 1)) != '0;
        out_of_range = 32'(word_idx) >= DEPTH;
        fault_c      = misalign || out_of_range;
    end

    assign run_o       = (state_q == ST_RUN);
    // A load restart in the same cycle wins over a fetch grant.
    assign fetch_gnt_o = run_o && fetch_req_i && (!rsp_valid_q || rsp_ready_i) && !load_start_i;

    // Control state machine.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (load_start_i) state_q <= ST_LOAD;
                ST_LOAD: if (load_start_i) state_q <= ST_LOAD;
                         else if (load_done_i) state_q <= ST_RUN;
                ST_RUN:  if (load_start_i) state_q <= ST_LOAD;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Load registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
            bc_q  <= '0;
            buf_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            bc_q  <= bc_d;
            buf_q <= buf_d;
            err_q <= err_d;
        end
    end

    // Response registers: hold under backpressure, drop on a load restart.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else if (load_start_i) begin
            rsp_valid_q <= 1'b0;
        end else if (fetch_gnt_o) begin
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= fault_c;
            rsp_data_q  <= fault_c ? FAULT_WORD : mem_q[MEM_AW'(word_idx)];
        end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign load_err_o     = err_q;
    assign loaded_words_o = ptr_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_fault_o    = rsp_fault_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: directed scenarios plus randomized loads and
// fetch traffic, compared against a byte-queue reference model.
module tb_instr_mem_loadable;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b1;
    logic              load_start_i = 1'b0;
    logic              load_byte_valid_i = 1'b0;
    logic [7:0]        load_byte_i = '0;
    logic              load_done_i = 1'b0;
    logic              load_err_o;
    logic [CNT_W-1:0]  loaded_words_o;
    logic              run_o;
    logic              fetch_req_i = 1'b0;
    logic [ADDR_W-1:0] fetch_addr_i = '0;
    logic              fetch_gnt_o;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_fault_o;

    instr_mem_loadable #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FAULT_WORD(32'h0000_0013)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .load_start_i(load_start_i), .load_byte_valid_i(load_byte_valid_i),
        .load_byte_i(load_byte_i), .load_done_i(load_done_i),
        .load_err_o(load_err_o), .loaded_words_o(loaded_words_o), .run_o(run_o),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_fault_o(rsp_fault_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: mode 0 idle, 1 loading, 2 running.
    int          mmode = 0;
    logic [7:0]  ld_q[$];
    logic [7:0]  prog_q[$];
    bit          err_m = 0;
    int          lw_m = 0;
    logic [31:0] mem_m [DEPTH];
    bit          known_m [DEPTH];
    bit          v_m = 0;
    logic [31:0] d_m = '0;
    bit          f_m = 0;
    bit          d_known = 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Words produced by a load of n bytes: little-endian, short tail zero-filled.
    task automatic commit_load();
        int n = ld_q.size();
        int words = (n + 3) / 4;
        for (int w = 0; w < words; w++) begin
            logic [31:0] word = '0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < n) word[8*k +: 8] = ld_q[4*w + k];
            mem_m[w]   = word;
            known_m[w] = 1;
        end
        lw_m = words;
    endtask

    // One clock: drive at the falling edge, check grant, update model at the
    // rising edge, then check registered outputs 1 ns later.
    task automatic tick(input bit start, input bit bv, input logic [7:0] b, input bit done,
                        input bit req, input logic [ADDR_W-1:0] addr, input bit rdy);
        bit g;
        int wi;
        @(negedge clk_i);
        load_start_i      = start;
        load_byte_valid_i = bv;
        load_byte_i       = b;
        load_done_i       = done;
        fetch_req_i       = req;
        fetch_addr_i      = addr;
        rsp_ready_i       = rdy;
        #1;
        g = (mmode == 2) && req && (!v_m || rdy) && !start;
        chk("gnt", 32'(fetch_gnt_o), 32'(g));
        @(posedge clk_i);
        if (start) begin
            mmode = 1; ld_q.delete(); err_m = 0; lw_m = 0; v_m = 0;
        end else begin
            if (mmode == 1) begin
                if (bv) begin
                    if (ld_q.size() < 4 * DEPTH) ld_q.push_back(b);
                    else err_m = 1;
                end
                lw_m = ld_q.size() / 4;
                if (done) begin
                    commit_load();
                    mmode = 2;
                end
            end
            if (g) begin
                wi  = int'(addr) / 4;
                v_m = 1;
                f_m = (addr % 4 != 0) || (wi >= DEPTH);
                if (f_m) begin
                    d_m = 32'h0000_0013; d_known = 1;
                end else begin
                    d_m = mem_m[wi]; d_known = known_m[wi];
                end
            end else if (rdy) begin
                v_m = 0;
            end
        end
        #1;
        chk("run", 32'(run_o), 32'(mmode == 2));
        chk("loaded_words", 32'(loaded_words_o), 32'(lw_m));
        chk("load_err", 32'(load_err_o), 32'(err_m));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(v_m));
        if (v_m) begin
            chk("rsp_fault", 32'(rsp_fault_o), 32'(f_m));
            if (d_known) chk("rsp_data", rsp_data_o, d_m);
        end
    endtask

    task automatic idle_tick(input bit rdy);
        tick(0, 0, 8'h00, 0, 0, '0, rdy);
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] addr);
        tick(0, 0, 8'h00, 0, 1, addr, 1);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if (lw_m > 0 && $urandom_range(0, 3) != 0)
            return ADDR_W'(4 * $urandom_range(0, lw_m - 1));
        return ADDR_W'($urandom_range(0, 2047));
    endfunction

    // Stream prog_q with random gaps; optionally fold the last byte into done.
    task automatic load_prog(input bit merge_last, input int max_gap);
        int n = prog_q.size();
        tick(1, 0, 8'h00, 0, 1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)));
        for (int i = 0; i < n; i++) begin
            int gaps = $urandom_range(0, max_gap);
            for (int j = 0; j < gaps; j++)
                tick(0, 0, 8'h00, 0, 1'($urandom_range(0, 1)), rand_addr(), 1);
            tick(0, 1, prog_q[i], merge_last && (i == n - 1), 1'($urandom_range(0, 1)),
                 rand_addr(), 1);
        end
        if (!merge_last || n == 0) tick(0, 0, 8'h00, 1, 0, '0, 1);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        mmode = 0; ld_q.delete(); err_m = 0; lw_m = 0;
        v_m = 0; d_m = '0; f_m = 0; d_known = 1;
        for (int i = 0; i < DEPTH; i++) known_m[i] = 0;
        chk("rst_run", 32'(run_o), 32'd0);
        chk("rst_err", 32'(load_err_o), 32'd0);
        chk("rst_loaded", 32'(loaded_words_o), 32'd0);
        chk("rst_gnt", 32'(fetch_gnt_o), 32'd0);
        chk("rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_data", rsp_data_o, 32'd0);
        chk("rst_fault", 32'(rsp_fault_o), 32'd0);
        load_start_i = 0; load_byte_valid_i = 0; load_done_i = 0;
        fetch_req_i = 0; rsp_ready_i = 0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] p;
        logic [31:0] held;
        logic [7:0]  last4 [4];

        for (int i = 0; i < DEPTH; i++) begin mem_m[i] = '0; known_m[i] = 0; end
        #2;
        do_reset();

        // Two-instruction program.
        p = 64'h0010_80B3_0010_8093;
        prog_q.delete();
        for (int k = 0; k < 8; k++) prog_q.push_back(p[8*k +: 8]);
        load_prog(0, 0);
        chk("tp1_loaded", 32'(loaded_words_o), 32'd2);
        chk("tp1_run", 32'(run_o), 32'd1);
        fetch(11'h000);
        chk("tp1_w0", rsp_data_o, 32'h0010_8093);
        fetch(11'h004);
        chk("tp1_w1", rsp_data_o, 32'h0010_80B3);
        chk("tp1_fault", 32'(rsp_fault_o), 32'd0);
        idle_tick(1);

        // Five bytes: tail word zero-extended.
        p = 64'h0000_0055_4433_2211;
        prog_q.delete();
        for (int k = 0; k < 5; k++) prog_q.push_back(p[8*k +: 8]);
        load_prog(0, 1);
        chk("tp2_loaded", 32'(loaded_words_o), 32'd2);
        fetch(11'h004);
        chk("tp2_w1", rsp_data_o, 32'h0000_0055);
        fetch(11'h000);
        chk("tp2_w0", rsp_data_o, 32'h4433_2211);

        // Faults.
        fetch(11'h002);
        chk("misalign_fault", 32'(rsp_fault_o), 32'd1);
        chk("misalign_data", rsp_data_o, 32'h0000_0013);
        fetch(11'h400);
        chk("range_fault", 32'(rsp_fault_o), 32'd1);
        idle_tick(1);

        // Backpressure: response holds, no grant, then immediate grant on release.
        fetch(11'h000);
        held = rsp_data_o;
        repeat (3) begin
            tick(0, 0, 8'h00, 0, 1, 11'h004, 0);
            chk("bp_gnt", 32'(fetch_gnt_o), 32'd0);
            chk("bp_hold", rsp_data_o, held);
        end
        tick(0, 0, 8'h00, 0, 1, 11'h004, 1);
        chk("bp_release", rsp_data_o, 32'h0000_0055);
        for (int i = 0; i < 4; i++) fetch(ADDR_W'(4 * (i % 2)));
        idle_tick(1);

        // Overflow: DEPTH*4+1 bytes.
        prog_q.delete();
        for (int i = 0; i < 4 * DEPTH + 1; i++) prog_q.push_back(8'($urandom));
        for (int k = 0; k < 4; k++) last4[k] = prog_q[4 * DEPTH - 4 + k];
        load_prog(0, 0);
        chk("ovf_err", 32'(load_err_o), 32'd1);
        chk("ovf_loaded", 32'(loaded_words_o), 32'(DEPTH));
        fetch(ADDR_W'(4 * (DEPTH - 1)));
        chk("ovf_last", rsp_data_o, {last4[3], last4[2], last4[1], last4[0]});
        tick(1, 0, 8'h00, 0, 0, '0, 1);
        chk("ovf_clear", 32'(load_err_o), 32'd0);
        tick(0, 0, 8'h00, 1, 0, '0, 1);

        // Reset after six bytes of a load.
        tick(1, 0, 8'h00, 0, 0, '0, 1);
        for (int i = 0; i < 6; i++) tick(0, 1, 8'(8'hA0 + i), 0, 0, '0, 1);
        do_reset();
        repeat (2) tick(0, 0, 8'h00, 0, 1, 11'h000, 1);

        // Randomized loads and fetch traffic, including loads restarted mid-run.
        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(1, 40);
            prog_q.delete();
            for (int i = 0; i < n; i++) prog_q.push_back(8'($urandom));
            load_prog(1'($urandom_range(0, 1)), 2);
            for (int c = 0; c < 60; c++)
                tick(0, 1'($urandom_range(0, 1)), 8'($urandom), 0,
                     1'($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 2) != 0));
        end
        idle_tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
